inst_buffer: RTL and testbench
==============================

Name: inst_buffer

Overview:
- Dual-port circular instruction queue between the fetch stage and the ID stage of the dual-issue core.
- Fetch pushes up to two {address, instruction} pairs per cycle.
- ID sees the two oldest entries combinationally and retires one or two of them per cycle, according to its issue decision.
- This block is the producer side of the dual-issue decode/operand-fetch path. Flush empties the queue.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- PTR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  drop all entries this cycle; highest priority after reset.
- push1_valid_i  in  1  fetch slot 1 carries a valid instruction.
- push1_inst_i  in  32  slot 1 instruction word.
- push1_addr_i  in  32  slot 1 PC.
- push2_valid_i  in  1  fetch slot 2 valid; only legal when push1_valid_i=1.
- push2_inst_i  in  32  slot 2 instruction word; younger than slot 1.
- push2_addr_i  in  32  slot 2 PC.
- pop_en_i  in  1  ID consumes this cycle (0 = ID stalled).
- issue_i  in  1  1 = dual issue (pop 2), 0 = single issue (pop 1).
- inst1_o  out  32  head instruction.
- inst1_addr_o  out  32  head PC.
- inst1_valid_o  out  1  count >= 1.
- inst2_o  out  32  head+1 instruction.
- inst2_addr_o  out  32  head+1 PC.
- inst2_valid_o  out  1  count >= 2.
- full_o  out  1  count > DEPTH-2; fetch must not push while high.
- empty_o  out  1  count == 0.

Behaviour:
- State: rd_ptr and wr_ptr, each PTR_W bits, wrapping modulo DEPTH; count, PTR_W+1 bits, range 0..DEPTH.
- Storage: DEPTH x 64-bit register array. Storage contents are not reset.
- Reset (async): rd_ptr=0, wr_ptr=0, count=0. Outputs are then inst*_valid_o=0, empty_o=1, full_o=0, and inst*/addr outputs=0.
- Read side, combinational from registered state:
  - entry[rd_ptr] drives inst1, entry[rd_ptr+1 mod DEPTH] drives inst2.
  - Data outputs are forced to 0 when the corresponding valid is 0.
- Pop amount: pop_n = 0 if pop_en_i=0. Otherwise pop_n = min(issue_i ? 2 : 1, count).
  - Dual request with count=1 pops 1. Pop with count=0 is a no-op.
- Push amount: push_n = push1_valid_i + (push1_valid_i & push2_valid_i).
  - push2 without push1 is ignored.
  - Slot 1 is written to wr_ptr and slot 2 to wr_ptr+1, both mod DEPTH.
- Push and pop are evaluated in the same cycle:
  - count_next = count - pop_n + push_n.
  - rd_ptr += pop_n, wr_ptr += push_n.
- full_o is derived from the registered count only. This guarantees room for 2 pushes regardless of the pop in the same cycle.
- Pushes while full_o=1 are a protocol violation. The block still performs them only if count + push_n - pop_n <= DEPTH; otherwise the whole push is dropped and state is unchanged except for the pop.
- Latency: a pushed entry is visible on the outputs in the cycle after the push edge. This holds even when the queue was empty; there is no bypass.
- flush=1 at an edge: rd_ptr=wr_ptr=0, count=0. Same-cycle push and pop are discarded.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Pointer wrap: slot 2 may land at index 0 when wr_ptr=DEPTH-1. inst2 may be read from index 0 when rd_ptr=DEPTH-1.
- Ordering: strict FIFO. Slot 1 is always older than slot 2, both on push and on output.

Test Plan:
- Reset then single push of (0xBFC00000, 0x24020001) -> next cycle inst1_valid_o=1, inst1_addr_o=0xBFC00000, inst2_valid_o=0, empty_o=0.
- Push pairs at 0x1000/0x1004, 0x1008/0x100C, no pop, 7 cycles (14 entries) -> count=14, full_o=0. One more pair -> count=16, full_o=1.
- Queue holds A,B,C; pop_en_i=1, issue_i=1 -> next cycle inst1=C, inst2_valid_o=0. Then dual pop with count=1 -> empty_o=1.
- Simultaneous dual push and dual pop at count=4 -> count stays 4, FIFO order preserved across 8 cycles with pointers wrapping past index 15.
- rd_ptr=15 with count=2 -> inst1 taken from entry 15 and inst2 from entry 0. Wr_ptr=15 with a dual push -> entries written at 15 and 0.
- Queue at count=6; flush=1 together with a push and a pop -> next cycle empty_o=1, all valids 0. Assert reset asynchronously between edges -> empty_o=1 before the next clk edge.

Source files
------------

// File: rtl/inst_buffer.sv
// inst_buffer: dual-port circular instruction queue between fetch and ID.
//   Fetch pushes up to two {addr, inst} pairs per cycle (slot 1 older than slot 2).
//   ID sees the two oldest entries combinationally and retires 0, 1 or 2 per cycle.
// Ports:
//   clk, reset (async, active-high), flush (empties the queue at the edge)
//   push1_*/push2_*  : fetch slots (valid, inst, addr); push2 needs push1
//   pop_en_i, issue_i: ID consume enable and dual(1)/single(0) issue select
//   inst1_*/inst2_*  : head and head+1 entries, data forced to 0 when invalid
//   full_o, empty_o  : registered-count status
module inst_buffer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PTR_W = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        push1_valid_i,
   input  logic [31:0] push1_inst_i,
   input  logic [31:0] push1_addr_i,
   input  logic        push2_valid_i,
   input  logic [31:0] push2_inst_i,
   input  logic [31:0] push2_addr_i,
   input  logic        pop_en_i,
   input  logic        issue_i,
   output logic [31:0] inst1_o,
   output logic [31:0] inst1_addr_o,
   output logic        inst1_valid_o,
   output logic [31:0] inst2_o,
   output logic [31:0] inst2_addr_o,
   output logic        inst2_valid_o,
   output logic        full_o,
   output logic        empty_o
);

   // Each entry is {addr, inst}.
   logic [63:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   logic [1:0]       pop_n;
   logic [1:0]       push_n;
   logic [PTR_W+1:0] count_sum;
   logic             push_ok;
   logic             do_push1;
   logic             do_push2;
   logic [PTR_W-1:0] rd_ptr_p1;
   logic [PTR_W-1:0] wr_ptr_p1;

   assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
   assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

   always_comb begin
      pop_n = 2'd0;
      if (pop_en_i && (count_q != '0)) begin
         // Dual request with only one entry retires just that one.
         pop_n = (issue_i && (count_q >= (PTR_W+1)'(2))) ? 2'd2 : 2'd1;
      end
   end

   // push2 alone is ignored.
   assign push_n = {1'b0, push1_valid_i} + {1'b0, push1_valid_i & push2_valid_i};

   // Pop never exceeds count, so the difference cannot underflow.
   assign count_sum = {1'b0, count_q} + (PTR_W+2)'(push_n) - (PTR_W+2)'(pop_n);
   // A push that would overflow (protocol violation while full) is dropped whole.
   assign push_ok   = (count_sum <= (PTR_W+2)'(DEPTH));

   assign do_push1 = !flush && push_ok && push1_valid_i;
   assign do_push2 = do_push1 && push2_valid_i;

   always_comb begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q - (PTR_W+1)'(pop_n);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
         count_d  = count_sum[PTR_W:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (do_push1) mem_q[wr_ptr_q]  <= {push1_addr_i, push1_inst_i};
      if (do_push2) mem_q[wr_ptr_p1] <= {push2_addr_i, push2_inst_i};
   end

   always_comb begin
      inst1_valid_o = (count_q != '0);
      inst2_valid_o = (count_q >= (PTR_W+1)'(2));
      empty_o       = (count_q == '0);
      full_o        = (count_q > (PTR_W+1)'(DEPTH - 2));
      inst1_o       = '0;
      inst1_addr_o  = '0;
      inst2_o       = '0;
      inst2_addr_o  = '0;
      if (inst1_valid_o) begin
         inst1_addr_o = mem_q[rd_ptr_q][63:32];
         inst1_o      = mem_q[rd_ptr_q][31:0];
      end
      if (inst2_valid_o) begin
         inst2_addr_o = mem_q[rd_ptr_p1][63:32];
         inst2_o      = mem_q[rd_ptr_p1][31:0];
      end
   end

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;

   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        push1_valid_i, push2_valid_i;
   logic [31:0] push1_inst_i, push1_addr_i, push2_inst_i, push2_addr_i;
   logic        pop_en_i, issue_i;
   logic [31:0] inst1_o, inst1_addr_o, inst2_o, inst2_addr_o;
   logic        inst1_valid_o, inst2_valid_o, full_o, empty_o;

   int tests_run = 0;
   int tests_failed = 0;

   // Expected queue contents, {addr, inst}, oldest first.
   logic [63:0] exp_q [$];

   inst_buffer #(.DEPTH(DEPTH), .PTR_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .push1_valid_i (push1_valid_i),
      .push1_inst_i  (push1_inst_i),
      .push1_addr_i  (push1_addr_i),
      .push2_valid_i (push2_valid_i),
      .push2_inst_i  (push2_inst_i),
      .push2_addr_i  (push2_addr_i),
      .pop_en_i      (pop_en_i),
      .issue_i       (issue_i),
      .inst1_o       (inst1_o),
      .inst1_addr_o  (inst1_addr_o),
      .inst1_valid_o (inst1_valid_o),
      .inst2_o       (inst2_o),
      .inst2_addr_o  (inst2_addr_o),
      .inst2_valid_o (inst2_valid_o),
      .full_o        (full_o),
      .empty_o       (empty_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard update: applies the accepted push/pop/flush at each edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
      end else if (flush) begin
         exp_q.delete();
      end else begin
         int pop_n;
         int push_n;
         int sz;
         sz     = exp_q.size();
         pop_n  = pop_en_i ? (issue_i ? 2 : 1) : 0;
         if (pop_n > sz) pop_n = sz;
         push_n = push1_valid_i ? (push2_valid_i ? 2 : 1) : 0;
         for (int i = 0; i < pop_n; i++) void'(exp_q.pop_front());
         if (sz - pop_n + push_n <= DEPTH) begin
            if (push_n >= 1) exp_q.push_back({push1_addr_i, push1_inst_i});
            if (push_n == 2) exp_q.push_back({push2_addr_i, push2_inst_i});
         end
      end
   end

   // Monitor: compares what the DUT presents against the scoreboard head.
   always @(negedge clk) begin
      int sz;
      sz = exp_q.size();
      check("mon_v1", {31'd0, inst1_valid_o}, {31'd0, sz >= 1});
      check("mon_v2", {31'd0, inst2_valid_o}, {31'd0, sz >= 2});
      check("mon_empty", {31'd0, empty_o}, {31'd0, sz == 0});
      check("mon_full", {31'd0, full_o}, {31'd0, sz > DEPTH - 2});
      check("mon_i1", inst1_o, (sz >= 1) ? exp_q[0][31:0] : 32'd0);
      check("mon_a1", inst1_addr_o, (sz >= 1) ? exp_q[0][63:32] : 32'd0);
      check("mon_i2", inst2_o, (sz >= 2) ? exp_q[1][31:0] : 32'd0);
      check("mon_a2", inst2_addr_o, (sz >= 2) ? exp_q[1][63:32] : 32'd0);
   end

   task automatic idle();
      flush = 0; push1_valid_i = 0; push2_valid_i = 0; pop_en_i = 0; issue_i = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic set_push(input logic v1, input logic [31:0] a1, input logic [31:0] i1,
                           input logic v2, input logic [31:0] a2, input logic [31:0] i2);
      push1_valid_i = v1; push1_addr_i = a1; push1_inst_i = i1;
      push2_valid_i = v2; push2_addr_i = a2; push2_inst_i = i2;
   endtask

   task automatic set_pop(input logic en, input logic dual);
      pop_en_i = en; issue_i = dual;
   endtask

   task automatic do_flush();
      flush = 1;
      step();
   endtask

   initial begin
      reset = 1;
      idle();
      set_push(0, 0, 0, 0, 0, 0);
      #12;
      check("rst_empty", {31'd0, empty_o}, 32'd1);
      check("rst_v1", {31'd0, inst1_valid_o}, 32'd0);
      check("rst_full", {31'd0, full_o}, 32'd0);
      check("rst_a1", inst1_addr_o, 32'd0);
      @(posedge clk); #1;
      reset = 0;

      // Single push after reset: visible next cycle.
      set_push(1, 32'hBFC0_0000, 32'h2402_0001, 0, 0, 0);
      step();
      check("sp_v1", {31'd0, inst1_valid_o}, 32'd1);
      check("sp_a1", inst1_addr_o, 32'hBFC0_0000);
      check("sp_i1", inst1_o, 32'h2402_0001);
      check("sp_v2", {31'd0, inst2_valid_o}, 32'd0);
      check("sp_empty", {31'd0, empty_o}, 32'd0);

      // Fill with 7 pairs -> 14 entries, then one more pair -> 16.
      do_flush();
      for (int k = 0; k < 7; k++) begin
         set_push(1, 32'h1000 + 32'(8 * k), 32'hA000 + 32'(k), 1, 32'h1004 + 32'(8 * k),
                  32'hB000 + 32'(k));
         step();
      end
      check("f14_full", {31'd0, full_o}, 32'd0);
      check("f14_v2", {31'd0, inst2_valid_o}, 32'd1);
      set_push(1, 32'h1038, 32'hA007, 1, 32'h103C, 32'hB007);
      step();
      check("f16_full", {31'd0, full_o}, 32'd1);
      // Overflowing push while full is dropped.
      set_push(1, 32'hDEAD, 32'hDEAD, 1, 32'hBEEF, 32'hBEEF);
      step();
      check("ovf_a1", inst1_addr_o, 32'h1000);
      check("ovf_full", {31'd0, full_o}, 32'd1);
      // Full with a dual pop: 16 - 2 + 2 fits.
      set_push(1, 32'h2000, 32'h1, 1, 32'h2004, 32'h2);
      set_pop(1, 1);
      step();
      check("fpp_a1", inst1_addr_o, 32'h1008);

      // A,B,C then dual pop -> C alone, then dual pop with count 1 -> empty.
      do_flush();
      set_push(1, 32'hA, 32'h11, 1, 32'hB, 32'h22);
      step();
      set_push(1, 32'hC, 32'h33, 0, 0, 0);
      step();
      set_pop(1, 1);
      step();
      check("abc_i1", inst1_o, 32'h33);
      check("abc_v2", {31'd0, inst2_valid_o}, 32'd0);
      set_pop(1, 1);
      step();
      check("abc_empty", {31'd0, empty_o}, 32'd1);

      // push2 without push1 is ignored.
      set_push(0, 0, 0, 1, 32'h77, 32'h77);
      step();
      check("p2only_empty", {31'd0, empty_o}, 32'd1);

      // Steady state at count 4 with dual push + dual pop, pointers wrap.
      set_push(1, 32'h3000, 32'h0, 1, 32'h3004, 32'h1);
      step();
      set_push(1, 32'h3008, 32'h2, 1, 32'h300C, 32'h3);
      step();
      for (int k = 0; k < 8; k++) begin
         set_push(1, 32'h3010 + 32'(8 * k), 32'(4 + 2 * k), 1, 32'h3014 + 32'(8 * k),
                  32'(5 + 2 * k));
         set_pop(1, 1);
         step();
         check("ss_i1", inst1_o, 32'(2 * k + 2));
      end
      check("ss_a1", inst1_addr_o, 32'h3040);

      // Move both pointers to 15, then dual push straddles the wrap.
      do_flush();
      for (int k = 0; k < 7; k++) begin
         set_push(1, 32'h0, 32'h0, 1, 32'h0, 32'h0);
         step();
      end
      set_push(1, 32'h0, 32'h0, 0, 0, 0);
      step();
      for (int k = 0; k < 7; k++) begin
         set_pop(1, 1);
         step();
      end
      set_pop(1, 0);
      step();
      check("wr_empty", {31'd0, empty_o}, 32'd1);
      set_push(1, 32'hF0F0, 32'h15, 1, 32'h0F0F, 32'h16);
      step();
      check("wr_a1", inst1_addr_o, 32'hF0F0);
      check("wr_a2", inst2_addr_o, 32'h0F0F);
      check("wr_i2", inst2_o, 32'h16);

      // Count 6 then flush with concurrent push and pop.
      set_push(1, 32'h1, 32'h1, 1, 32'h2, 32'h2);
      step();
      set_push(1, 32'h3, 32'h3, 1, 32'h4, 32'h4);
      step();
      flush = 1;
      set_push(1, 32'h5, 32'h5, 1, 32'h6, 32'h6);
      set_pop(1, 1);
      step();
      check("fl_empty", {31'd0, empty_o}, 32'd1);
      check("fl_v1", {31'd0, inst1_valid_o}, 32'd0);
      check("fl_v2", {31'd0, inst2_valid_o}, 32'd0);

      // Async reset between edges.
      set_push(1, 32'h9, 32'h9, 1, 32'hA, 32'hA);
      step();
      check("ar_pre", {31'd0, empty_o}, 32'd0);
      #1;
      reset = 1;
      #1;
      check("ar_empty", {31'd0, empty_o}, 32'd1);
      check("ar_v1", {31'd0, inst1_valid_o}, 32'd0);
      step();
      reset = 0;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
